// File: rtl/filter_endpoint_pkg.sv
// Shared definitions for the filter endpoint slice.
// Holds the default sample width and FIFO depth, and the state encodings
// of the source and sink handshake FSMs.
package filter_endpoint_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [0:0] {
        SRC_IDLE = 1'b0,
        SRC_ACK  = 1'b1
    } src_state_t;

    typedef enum logic [0:0] {
        SNK_IDLE = 1'b0,
        SNK_ACK  = 1'b1
    } snk_state_t;

endpackage

// File: rtl/endpoint_fifo.sv
// Source-side word FIFO with its pointers and occupancy count.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write strobe and word (ignored while full)
//   pop             remove the head word (ignored while empty)
//   head            word at the read pointer
//   empty           no word stored
//   full            DEPTH words stored (registered)
//   overflow        sticky: a push was attempted while full
module endpoint_fifo
    import filter_endpoint_pkg::*;
#(
    parameter int DDWIDTH = 2 * DWIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [DDWIDTH-1:0] push_data,
    input  logic               pop,
    output logic [DDWIDTH-1:0] head,
    output logic               empty,
    output logic               full,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DDWIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [CW-1:0]      count_nxt_s;
    logic               full_r;
    logic               overflow_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    // Gate push/pop so a full FIFO drops writes and an empty one ignores reads.
    always_comb begin
        push_ok_s = push & ~full_r;
        pop_ok_s  = pop & (count_r != {CW{1'b0}});
    end

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and flags; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            if (push & full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Storage array; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head     = mem_r[rd_ptr_r];
    assign empty    = (count_r == {CW{1'b0}});
    assign full     = full_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/filter_endpoint.sv
// Filter endpoint: a FIFO-backed four-phase source channel and a
// single-slot four-phase sink channel, running independently.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   wr_en, wr_data             push into the source FIFO
//   full, overflow             FIFO full / sticky dropped-push flag
//   req_src, ack_src, data_src source handshake toward the consumer
//   req_snk, ack_snk, data_snk sink handshake from the producer
//   out_valid, out_ready, out_data  captured word toward the local consumer
module filter_endpoint
    import filter_endpoint_pkg::*;
#(
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int DDWIDTH = 2 * DWIDTH,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [DDWIDTH-1:0] wr_data,
    output logic               full,
    output logic               overflow,
    input  logic               req_src,
    output logic               ack_src,
    output logic [DDWIDTH-1:0] data_src,
    input  logic               req_snk,
    output logic               ack_snk,
    input  logic [DDWIDTH-1:0] data_snk,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DDWIDTH-1:0] out_data
);

    src_state_t         src_state_r;
    src_state_t         src_state_nxt_s;
    snk_state_t         snk_state_r;
    snk_state_t         snk_state_nxt_s;
    logic               fifo_empty_s;
    logic [DDWIDTH-1:0] fifo_head_s;
    logic               src_load_s;
    logic               src_pop_s;
    logic               snk_cap_s;
    logic               ack_src_r;
    logic [DDWIDTH-1:0] data_src_r;
    logic               ack_snk_r;
    logic               out_valid_r;
    logic [DDWIDTH-1:0] out_data_r;

    endpoint_fifo #(
        .DDWIDTH (DDWIDTH),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (src_pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .full      (full),
        .overflow  (overflow)
    );

    // State registers for both handshake FSMs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_state_r <= SRC_IDLE;
            snk_state_r <= SNK_IDLE;
        end else begin
            src_state_r <= src_state_nxt_s;
            snk_state_r <= snk_state_nxt_s;
        end
    end

    // Next-state logic; an empty FIFO keeps the source waiting indefinitely.
    always_comb begin
        src_state_nxt_s = src_state_r;
        case (src_state_r)
            SRC_IDLE: begin
                if (req_src && !fifo_empty_s) src_state_nxt_s = SRC_ACK;
                else                          src_state_nxt_s = SRC_IDLE;
            end
            SRC_ACK: begin
                if (!req_src) src_state_nxt_s = SRC_IDLE;
                else          src_state_nxt_s = SRC_ACK;
            end
            default: src_state_nxt_s = SRC_IDLE;
        endcase

        snk_state_nxt_s = snk_state_r;
        case (snk_state_r)
            SNK_IDLE: begin
                if (snk_cap_s) snk_state_nxt_s = SNK_ACK;
                else           snk_state_nxt_s = SNK_IDLE;
            end
            SNK_ACK: begin
                if (!req_snk) snk_state_nxt_s = SNK_IDLE;
                else          snk_state_nxt_s = SNK_ACK;
            end
            default: snk_state_nxt_s = SNK_IDLE;
        endcase
    end

    // Control strobes: the head is popped only when the consumer drops its request,
    // and a capture is allowed when the slot is free or being drained this cycle.
    always_comb begin
        src_load_s = 1'b0;
        src_pop_s  = 1'b0;
        snk_cap_s  = 1'b0;
        case (src_state_r)
            SRC_IDLE: src_load_s = req_src & ~fifo_empty_s;
            SRC_ACK:  src_pop_s  = ~req_src;
            default:  src_load_s = 1'b0;
        endcase
        case (snk_state_r)
            SNK_IDLE: snk_cap_s = req_snk & (~out_valid_r | out_ready);
            SNK_ACK:  snk_cap_s = 1'b0;
            default:  snk_cap_s = 1'b0;
        endcase
    end

    // Registered outputs of both channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_src_r   <= 1'b0;
            data_src_r  <= {DDWIDTH{1'b0}};
            ack_snk_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DDWIDTH{1'b0}};
        end else begin
            ack_src_r <= (src_state_nxt_s == SRC_ACK);
            ack_snk_r <= (snk_state_nxt_s == SNK_ACK);
            if (src_load_s) begin
                data_src_r <= fifo_head_s;
            end
            if (snk_cap_s) begin
                out_data_r  <= data_snk;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign ack_src   = ack_src_r;
    assign data_src  = data_src_r;
    assign ack_snk   = ack_snk_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_filter_endpoint.sv
// Self-checking bench for filter_endpoint: directed scenarios followed by
// randomized concurrent traffic on both channels, checked every cycle
// against a queue-based reference model of the two channels.
module tb_filter_endpoint;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full, overflow;
    logic          req_src = 1'b0;
    logic          ack_src;
    logic [DW-1:0] data_src;
    logic          req_snk = 1'b0;
    logic          ack_snk;
    logic [DW-1:0] data_snk = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_ack_src, m_ack_snk, m_valid;
    logic [DW-1:0] m_data_src, m_out_data;

    filter_endpoint #(.DWIDTH(16), .DDWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .overflow(overflow),
        .req_src(req_src), .ack_src(ack_src), .data_src(data_src),
        .req_snk(req_snk), .ack_snk(ack_snk), .data_snk(data_snk),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0; m_ack_src = 1'b0; m_ack_snk = 1'b0; m_valid = 1'b0;
        m_data_src = '0; m_out_data = '0;
    endtask

    // Advance one clock with the current inputs, update the model, compare everything.
    task automatic step();
        bit full_b;
        full_b = (mq.size() == DEPTH);
        if (!m_ack_src && req_src && mq.size() > 0) begin
            m_ack_src  = 1'b1;
            m_data_src = mq[0];
        end else if (m_ack_src && !req_src) begin
            m_ack_src = 1'b0;
            void'(mq.pop_front());
        end
        if (wr_en) begin
            if (full_b) m_ovf = 1'b1;
            else        mq.push_back(wr_data);
        end
        if (!m_ack_snk && req_snk && (!m_valid || out_ready)) begin
            m_ack_snk  = 1'b1;
            m_valid    = 1'b1;
            m_out_data = data_snk;
        end else begin
            if (m_ack_snk && !req_snk) m_ack_snk = 1'b0;
            if (m_valid && out_ready)  m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("ack_src",   ack_src,   m_ack_src);
        check_eq("data_src",  data_src,  m_data_src);
        check_eq("full",      full,      mq.size() == DEPTH);
        check_eq("overflow",  overflow,  m_ovf);
        check_eq("ack_snk",   ack_snk,   m_ack_snk);
        check_eq("out_valid", out_valid, m_valid);
        check_eq("out_data",  out_data,  m_out_data);
    endtask

    // Assert reset away from the edge, check the asynchronous effect, then release.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_ack_src",   ack_src,   1'b0);
        check_eq("rst_ack_snk",   ack_snk,   1'b0);
        check_eq("rst_full",      full,      1'b0);
        check_eq("rst_overflow",  overflow,  1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_data_src",  data_src,  32'h0);
        check_eq("rst_out_data",  out_data,  32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        wr_en = 1'b1; wr_data = w;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // two pushes, two source handshakes with 1-cycle ack latency
        push_word(32'h00010002);
        push_word(32'h00030004);
        req_src = 1'b1; step();
        check_eq("t1_ack1", ack_src, 1'b1);
        check_eq("t1_data1", data_src, 32'h00010002);
        req_src = 1'b0; step(); step();
        req_src = 1'b1; step();
        check_eq("t1_ack2", ack_src, 1'b1);
        check_eq("t1_data2", data_src, 32'h00030004);
        req_src = 1'b0; step();

        // fill to DEPTH, ninth push dropped, drain in order
        for (int i = 1; i <= 9; i++) begin
            push_word(DW'(i));
            if (i == 8) check_eq("t2_full8", full, 1'b1);
        end
        check_eq("t2_ovf", overflow, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            req_src = 1'b1; step();
            check_eq("t2_pop_data", data_src, DW'(i));
            req_src = 1'b0; step();
        end
        check_eq("t2_full_after", full, 1'b0);
        check_eq("t2_ovf_sticky", overflow, 1'b1);

        // request on an empty FIFO waits without timeout
        do_reset();
        req_src = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check_eq("t3_no_ack", ack_src, 1'b0);
        push_word(32'hCAFE0001);
        check_eq("t3_ack_not_yet", ack_src, 1'b0);
        step();
        check_eq("t3_ack", ack_src, 1'b1);
        check_eq("t3_data", data_src, 32'hCAFE0001);
        req_src = 1'b0; step();

        // sink capture and backpressure
        out_ready = 1'b0;
        req_snk = 1'b1; data_snk = 32'hDEADBEEF; step();
        check_eq("t4_ack", ack_snk, 1'b1);
        check_eq("t4_valid", out_valid, 1'b1);
        check_eq("t4_data", out_data, 32'hDEADBEEF);
        req_snk = 1'b0; step();
        req_snk = 1'b1; data_snk = 32'h12345678;
        for (int i = 0; i < 3; i++) step();
        check_eq("t4_bp_ack", ack_snk, 1'b0);
        check_eq("t4_bp_data", out_data, 32'hDEADBEEF);
        out_ready = 1'b1; step();
        check_eq("t4_ack2", ack_snk, 1'b1);
        check_eq("t4_data2", out_data, 32'h12345678);
        out_ready = 1'b0; req_snk = 1'b0; step();
        out_ready = 1'b1; step();
        check_eq("t4_drained", out_valid, 1'b0);
        out_ready = 1'b0;

        // reset in the middle of a source handshake
        push_word(32'hA0000001);
        push_word(32'hA0000002);
        push_word(32'hA0000003);
        req_src = 1'b1; step();
        check_eq("t5_ack_before", ack_src, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check_eq("t5_no_ack", ack_src, 1'b0);
        push_word(32'hB0000001);
        step();
        check_eq("t5_ack_new", ack_src, 1'b1);
        check_eq("t5_data_new", data_src, 32'hB0000001);
        req_src = 1'b0; step();

        // randomized concurrent traffic on both channels
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_data = $urandom;
            if (!req_src && !m_ack_src)     req_src = $urandom_range(0, 1);
            else if (req_src && m_ack_src)  req_src = $urandom_range(0, 1) == 0;
            if (!req_snk && !m_ack_snk) begin
                req_snk  = $urandom_range(0, 1);
                data_snk = $urandom;
            end else if (req_snk && m_ack_snk) begin
                req_snk = $urandom_range(0, 1) == 0;
            end
            out_ready = $urandom_range(0, 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_endpoint.md
FILTER_ENDPOINT -- requirements
Module: filter_endpoint

Interface
REQ-001 Parameters SHALL be: DWIDTH, default 16, sample half-width; DDWIDTH, default 2*DWIDTH, word width on both channels; DEPTH, default 8, source FIFO depth (power of two, at least 2).
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push strobe into the source FIFO.
- wr_data  in  DDWIDTH  word pushed when wr_en is high.
- full  out  1  source FIFO holds DEPTH words.
- overflow  out  1  sticky flag: a push was attempted while full.
- req_src  in  1  consumer request for one word.
- ack_src  out  1  word on data_src is valid.
- data_src  out  DDWIDTH  word served to the consumer.
- req_snk  in  1  producer offers one word.
- ack_snk  out  1  offered word captured.
- data_snk  in  DDWIDTH  word offered by the producer.
- out_valid  out  1  captured word is pending on out_data.
- out_ready  in  1  local consumer takes out_data.
- out_data  out  DDWIDTH  captured word.

Function
REQ-003 Both channels SHALL be four-phase: request high, then ack high, then request low, then ack low; a new request is honoured only after ack is low.
REQ-004 The source FIFO SHALL accept a push when wr_en is high and full is low; the count increments one cycle later.
REQ-005 A push while full SHALL be dropped, and overflow SHALL set and stay set until reset.
REQ-006 The source FSM SHALL have states SRC_IDLE and SRC_ACK.
REQ-007 In SRC_IDLE, when req_src is high and the FIFO is not empty, the FSM SHALL load the FIFO head into data_src, set ack_src the next cycle and enter SRC_ACK.
- Latency from req_src rising to ack_src rising is 1 cycle.
REQ-008 In SRC_IDLE with the FIFO empty, ack_src SHALL stay low and the FSM SHALL wait without a timeout.
REQ-009 In SRC_ACK, data_src SHALL stay stable.
- When req_src is sampled low: clear ack_src, pop the head (read pointer +1 modulo DEPTH, count -1), return to SRC_IDLE.
REQ-010 A push and a pop in the same cycle SHALL leave the count unchanged; both pointers wrap modulo DEPTH.
REQ-011 The sink FSM SHALL have states SNK_IDLE and SNK_ACK.
REQ-012 In SNK_IDLE, when req_snk is high and out_valid is low (or out_ready is high in the same cycle), the FSM SHALL capture data_snk into out_data, set out_valid and ack_snk the next cycle, and enter SNK_ACK.
REQ-013 In SNK_IDLE, while out_valid is high and out_ready is low, ack_snk SHALL stay low (backpressure).
REQ-014 In SNK_ACK, when req_snk is sampled low, the FSM SHALL clear ack_snk and return to SNK_IDLE.
REQ-015 out_valid SHALL clear one cycle after out_valid and out_ready are both high, unless a new capture occurs in that cycle.
REQ-016 The two channels SHALL operate independently and concurrently.
REQ-017 The block SHALL have no arithmetic on data; words pass bit-exact.

Reset
REQ-018 On rst high, asynchronously:
- ack_src, ack_snk, out_valid, full and overflow SHALL go to 0.
- data_src and out_data SHALL go to 0.
- Pointers and count SHALL go to 0, and both FSMs SHALL enter IDLE.
REQ-019 Reset mid-handshake SHALL drop ack immediately and discard FIFO contents; no pop or capture completes.

Structure
REQ-020 A shared package SHALL hold the FSM state encodings and the default DWIDTH and DEPTH constants.
REQ-021 The FIFO storage with its pointers and count SHALL be one sub-module, endpoint_fifo; both FSMs live in filter_endpoint.

Verification
REQ-022 Push 0x00010002 and 0x00030004, then raise req_src twice -> ack_src after 1 cycle each time; data_src reads 0x00010002 then 0x00030004.
REQ-023 Push 9 words with DEPTH=8 -> full high after the 8th push; the 9th is dropped; overflow=1; 8 pops return words 1..8 in order.
REQ-024 req_src high with the FIFO empty for 20 cycles, then one push -> ack_src rises 1 cycle after the FIFO becomes non-empty.
REQ-025 req_snk with 0xDEADBEEF while out_ready=0 -> captured, out_valid=1; a second req_snk is not acked until out_ready=1.
REQ-026 Assert rst while ack_src=1 with 3 words stored -> ack_src=0 immediately; full=0; a following req_src gets no ack until a new push.
